// File: rtl/sd_arbiter.sv
// rtl/sd_arbiter.sv - two-client arbiter for the mist_io SD block-access port
// One transaction at a time; buffer traffic is routed only to the granted client.
module sd_arbiter #(
  parameter int TO_BITS = 24
) (
  input  logic        i_clk_sys,
  input  logic        i_reset_n,
  input  logic [31:0] i_c0_lba,
  input  logic        i_c0_rd,
  input  logic        i_c0_wr,
  output logic        o_c0_ack,
  output logic        o_c0_done,
  output logic        o_c0_err,
  output logic        o_c0_buff_wr,
  input  logic [7:0]  i_c0_buff_din,
  input  logic [31:0] i_c1_lba,
  input  logic        i_c1_rd,
  input  logic        i_c1_wr,
  output logic        o_c1_ack,
  output logic        o_c1_done,
  output logic        o_c1_err,
  output logic        o_c1_buff_wr,
  input  logic [7:0]  i_c1_buff_din,
  output logic [31:0] o_sd_lba,
  output logic        o_sd_rd,
  output logic        o_sd_wr,
  input  logic        i_sd_ack,
  input  logic        i_sd_buff_wr,
  output logic [7:0]  o_sd_buff_din
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_ack_sync;
  logic                r_grant;
  logic                r_last_grant;
  logic [31:0]         r_lba;
  logic                r_op_rd;
  logic                r_op_wr;
  logic [TO_BITS-1:0]  r_timer;
  logic                r_done0;
  logic                r_done1;
  logic                r_err0;
  logic                r_err1;

  logic                w_ack_s;
  logic                w_pend0;
  logic                w_pend1;
  logic                w_any;
  logic                w_pick;
  logic                w_pick_rd;
  logic                w_pick_wr;
  logic [31:0]         w_pick_lba;
  logic [TO_BITS-1:0]  w_timer_inc;
  logic                w_timeout;
  logic                w_active;

  // sd_ack comes from the SPI domain; only the second stage is ever used
  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) r_ack_sync <= 2'b00;
    else            r_ack_sync <= {r_ack_sync[0], i_sd_ack};
  end

  assign w_ack_s     = r_ack_sync[1];
  assign w_pend0     = i_c0_rd | i_c0_wr;
  assign w_pend1     = i_c1_rd | i_c1_wr;
  assign w_any       = w_pend0 | w_pend1;
  assign w_pick      = (w_pend0 && w_pend1) ? ~r_last_grant : w_pend1;
  assign w_pick_rd   = w_pick ? i_c1_rd  : i_c0_rd;
  assign w_pick_wr   = w_pick ? i_c1_wr  : i_c0_wr;
  assign w_pick_lba  = w_pick ? i_c1_lba : i_c0_lba;
  assign w_timer_inc = r_timer + 1'b1;
  assign w_timeout   = (w_timer_inc == '1);
  assign w_active    = (r_state == S_REQ) || (r_state == S_BUSY);

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_REQ;
      S_REQ: begin
        if (w_ack_s)        w_next = S_BUSY;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_BUSY: if (!w_ack_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction context and completion pulses, registered alongside the state
  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_lba        <= 32'd0;
      r_op_rd      <= 1'b0;
      r_op_wr      <= 1'b0;
      r_timer      <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_lba   <= w_pick_lba;
            r_op_rd <= w_pick_rd;
            r_op_wr <= w_pick_wr & ~w_pick_rd;
            r_timer <= '0;
          end
        end
        S_REQ: begin
          r_timer <= w_timer_inc;
          if (!w_ack_s && w_timeout) begin
            r_err0       <= ~r_grant;
            r_err1       <= r_grant;
            r_last_grant <= r_grant;
          end
        end
        S_BUSY: begin
          if (!w_ack_s) begin
            r_done0      <= ~r_grant;
            r_done1      <= r_grant;
            r_last_grant <= r_grant;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_sd_rd      = (r_state == S_REQ) & r_op_rd;
    o_sd_wr      = (r_state == S_REQ) & r_op_wr;
    o_c0_ack     = w_active & ~r_grant & w_ack_s;
    o_c1_ack     = w_active &  r_grant & w_ack_s;
    o_c0_buff_wr = w_active & ~r_grant & i_sd_buff_wr;
    o_c1_buff_wr = w_active &  r_grant & i_sd_buff_wr;
  end

  assign o_sd_lba      = r_lba;
  assign o_sd_buff_din = r_grant ? i_c1_buff_din : i_c0_buff_din;
  assign o_c0_done     = r_done0;
  assign o_c1_done     = r_done1;
  assign o_c0_err      = r_err0;
  assign o_c1_err      = r_err1;

endmodule
